// File: rtl/ascii_num_parser_pkg.sv
// Shared types and ASCII constants for the ASCII number parser.
// Optional overflow detection in the top is enabled by ASCII_NUM_PARSER_OVF_EN.
package ascii_num_parser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam logic [7:0] ZERO = 8'h30;
   localparam logic [7:0] NINE = 8'h39;
   localparam logic [7:0] LA   = 8'h61;
   localparam logic [7:0] LF   = 8'h66;
   localparam logic [7:0] UA   = 8'h41;
   localparam logic [7:0] UF   = 8'h46;

endpackage

// File: rtl/ascii_num_parser_if.sv
// Character stream in, parsed number and status out.
// Handshake: a char is consumed on every rising edge where char_valid is high
// and the parser is in ACCUM; there is no ready, the parser never stalls.
interface ascii_num_parser_if
   import ascii_num_parser_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MAX_DIGITS = 8
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   logic             start;
   logic             hex_mode;
   logic             char_valid;
   logic [7:0]       char;
   logic [WIDTH-1:0] value;
   logic [CW-1:0]    digit_cnt;
   logic             busy;
   logic             done;
   logic             err;
   logic             ovf;
   state_t           state;

   modport master (
      output start, hex_mode, char_valid, char,
      input  value, digit_cnt, busy, done, err, ovf, state
   );

   modport slave (
      input  start, hex_mode, char_valid, char,
      output value, digit_cnt, busy, done, err, ovf, state
   );

endinterface

// File: rtl/ascii_num_parser_digit_decode.sv
// Combinational ASCII-to-digit decoder; letters a-f/A-F count only in hex.
module ascii_digit_decode
   import ascii_num_parser_pkg::*;
(
   input  logic [7:0] char,
   input  logic       hex,
   output logic [3:0] digit,
   output logic       is_digit
);

   always_comb begin
      digit    = 4'd0;
      is_digit = 1'b0;
      if (char >= ZERO && char <= NINE) begin
         digit    = char[3:0];
         is_digit = 1'b1;
      end else if (hex && ((char >= LA && char <= LF) || (char >= UA && char <= UF))) begin
         // Both letter ranges start at low nibble 1, so nibble+9 yields 10..15.
         digit    = char[3:0] + 4'd9;
         is_digit = 1'b1;
      end
   end

endmodule

// File: rtl/ascii_num_parser.sv
// Accumulates a decimal or hex ASCII number one char per clock.
// Define ASCII_NUM_PARSER_OVF_EN to flag overflow instead of wrapping.
module ascii_num_parser
   import ascii_num_parser_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MAX_DIGITS = 8
)(
   input logic                clk,
   input logic                reset,
   ascii_num_parser_if.slave  bus
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   state_t           state;
   logic             hex_q;
   logic [WIDTH-1:0] value_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       digit;
   logic             is_digit;
   logic [WIDTH-1:0] acc_next;
   logic             ovf_hit;

   ascii_digit_decode u_decode (
      .char     (bus.char),
      .hex      (hex_q),
      .digit    (digit),
      .is_digit (is_digit)
   );

`ifdef ASCII_NUM_PARSER_OVF_EN
   logic             ovf_q;
   logic [WIDTH+4:0] wide_val;
   logic [WIDTH+4:0] wide_sum;

   // Five spare bits hold value*16+15, the largest possible step.
   assign wide_val = {5'd0, value_q};
   assign wide_sum = (hex_q ? (wide_val << 4) : ((wide_val << 3) + (wide_val << 1)))
                   + {{(WIDTH+1){1'b0}}, digit};
   assign acc_next = wide_sum[WIDTH-1:0];
   assign ovf_hit  = |wide_sum[WIDTH+4:WIDTH];
   assign bus.ovf  = ovf_q;
`else
   assign acc_next = (hex_q ? (value_q << 4) : ((value_q << 3) + (value_q << 1)))
                   + {{(WIDTH-4){1'b0}}, digit};
   assign ovf_hit  = 1'b0;
   assign bus.ovf  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         value_q <= '0;
         cnt_q   <= '0;
         hex_q   <= 1'b0;
`ifdef ASCII_NUM_PARSER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else if (bus.start) begin
         state   <= ACCUM;
         value_q <= '0;
         cnt_q   <= '0;
         hex_q   <= bus.hex_mode;
`ifdef ASCII_NUM_PARSER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ACCUM: begin
               if (bus.char_valid) begin
                  if (is_digit) begin
                     if (cnt_q == CW'(MAX_DIGITS)) begin
                        state <= ERR;
                     end else if (ovf_hit) begin
                        state <= ERR;
`ifdef ASCII_NUM_PARSER_OVF_EN
                        ovf_q <= 1'b1;
`endif
                     end else begin
                        value_q <= acc_next;
                        cnt_q   <= cnt_q + 1'b1;
                     end
                  end else if (cnt_q != '0) begin
                     state <= DONE;
                  end else begin
                     state <= ERR;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= state;
         endcase
      end
   end

   assign bus.value     = value_q;
   assign bus.digit_cnt = cnt_q;
   assign bus.busy      = (state == ACCUM);
   assign bus.done      = (state == DONE);
   assign bus.err       = (state == ERR);
   assign bus.state     = state;

endmodule

// File: tb/tb_ascii_num_parser.sv
// Directed bench for ascii_num_parser: a 32-bit instance and an 8-bit one for wrap/overflow.
module tb_ascii_num_parser;
   import ascii_num_parser_pkg::*;

   logic clk;
   logic reset;
   int   vec_cnt;
   int   miss_cnt;

   ascii_num_parser_if #(.WIDTH(32), .MAX_DIGITS(8)) bus  ();
   ascii_num_parser_if #(.WIDTH(8),  .MAX_DIGITS(8)) bus8 ();

   ascii_num_parser #(.WIDTH(32), .MAX_DIGITS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   ascii_num_parser #(.WIDTH(8), .MAX_DIGITS(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are set at a falling edge; outputs are sampled at the next falling edge.
   task automatic drive(input logic st, input logic hx, input logic cv, input logic [7:0] ch);
      bus.start = st; bus.hex_mode = hx; bus.char_valid = cv; bus.char = ch;
      @(negedge clk);
      bus.start = 1'b0; bus.char_valid = 1'b0;
   endtask

   task automatic drive8(input logic st, input logic cv, input logic [7:0] ch);
      bus8.start = st; bus8.hex_mode = 1'b0; bus8.char_valid = cv; bus8.char = ch;
      @(negedge clk);
      bus8.start = 1'b0; bus8.char_valid = 1'b0;
   endtask

   initial begin
      vec_cnt = 0; miss_cnt = 0;
      bus.start = 0; bus.hex_mode = 0; bus.char_valid = 0; bus.char = 8'h00;
      bus8.start = 0; bus8.hex_mode = 0; bus8.char_valid = 0; bus8.char = 8'h00;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      check("rst_value", bus.value, 0);
      check("rst_cnt",   bus.digit_cnt, 0);
      check("rst_flags", {bus.busy, bus.done, bus.err, bus.ovf}, 4'b0000);

      // Decimal "123;"
      drive(1, 0, 0, 8'h00);
      check("dec_busy", bus.busy, 1);
      drive(0, 0, 1, "1");
      drive(0, 0, 1, "2");
      drive(0, 0, 1, "3");
      check("dec_acc", bus.value, 123);
      check("dec_done_early", bus.done, 0);
      drive(0, 0, 1, ";");
      check("dec_done", bus.done, 1);
      check("dec_value", bus.value, 123);
      check("dec_cnt", bus.digit_cnt, 3);
      check("dec_err", bus.err, 0);
      drive(0, 0, 1, "9");
      check("dec_idle_done", {bus.done, bus.busy}, 2'b00);
      check("idle_ignores_char", bus.value, 123);

      // Hex "Ab0#"
      drive(1, 1, 0, 8'h00);
      drive(0, 0, 1, "A");
      drive(0, 0, 1, "b");
      drive(0, 0, 1, "0");
      drive(0, 0, 1, "#");
      check("hex_done", bus.done, 1);
      check("hex_value", bus.value, 32'h0000_0AB0);

      // Hex "fF;" with hex_mode dropped after start: radix stays latched
      drive(1, 1, 0, 8'h00);
      drive(0, 0, 1, "f");
      drive(0, 0, 1, "F");
      drive(0, 0, 1, ";");
      check("hex_ff", {bus.done, bus.value}, {1'b1, 32'hFF});

      // Same letters in decimal: error on 'A', no done
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, "A");
      check("dec_letter_err", {bus.err, bus.done, bus.busy}, 3'b100);
      drive(0, 0, 1, "#");
      check("err_holds", {bus.err, bus.done}, 2'b10);

      // Immediate terminator
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, "#");
      check("empty_err", {bus.err, bus.done}, 2'b10);
      drive(0, 0, 0, 8'h00);
      check("empty_no_done", bus.done, 0);
      drive(1, 0, 0, 8'h00);
      check("start_clears_err", {bus.err, bus.busy}, 2'b01);

      // Nine digits: ninth is rejected
      for (int i = 1; i <= 8; i++) drive(0, 0, 1, 8'h30 + 8'(i));
      check("max_value", bus.value, 12345678);
      check("max_cnt", bus.digit_cnt, 8);
      drive(0, 0, 1, "9");
      check("ninth_err", {bus.err, bus.done}, 2'b10);
      check("ninth_value", bus.value, 12345678);

      // Hold while char_valid low
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, "4");
      drive(0, 0, 0, "7");
      check("hold_no_valid", {bus.busy, bus.value}, {1'b1, 32'd4});

      // Reset mid-number
      drive(0, 0, 1, "5");
      check("pre_reset", bus.value, 45);
      reset = 1'b1;
      drive(1, 0, 1, "6");
      reset = 1'b0;
      check("reset_abort", {bus.busy, bus.done, bus.err}, 3'b000);
      check("reset_value", bus.value, 0);

      // start together with a char mid-number
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, "7");
      drive(1, 0, 1, "9");
      check("start_prio", {bus.busy, bus.value, bus.digit_cnt}, {1'b1, 32'd0, 4'd0});
      drive(0, 0, 1, "5");
      check("after_restart", bus.value, 5);

      // 8-bit instance: "300;"
      drive8(1, 0, 8'h00);
      drive8(0, 1, "3");
      drive8(0, 1, "0");
      drive8(0, 1, "0");
`ifdef ASCII_NUM_PARSER_OVF_EN
      check("w8_ovf_flags", {bus8.err, bus8.ovf, bus8.done}, 3'b110);
      check("w8_ovf_value", bus8.value, 30);
      drive8(1, 0, 8'h00);
      check("w8_ovf_clear", {bus8.err, bus8.ovf}, 2'b00);
`else
      drive8(0, 1, ";");
      check("w8_wrap_done", {bus8.done, bus8.err, bus8.ovf}, 3'b100);
      check("w8_wrap_value", bus8.value, 44);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ascii_num_parser.md
ASCII_NUM_PARSER -- requirements
Module: ascii_num_parser

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the accumulated value.
REQ-002 Parameter MAX_DIGITS, default 8: maximum digits accepted per number.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a new number and clears the accumulator.
REQ-006 hex_mode  input  1  radix select, sampled only on start: 0 = decimal, 1 = hex.
REQ-007 char_valid  input  1  char is presented this cycle.
REQ-008 char  input  8  ASCII character.
REQ-009 value  output  WIDTH  accumulated number, held after done.
REQ-010 digit_cnt  output  $clog2(MAX_DIGITS+1)  digits accepted so far.
REQ-011 busy  output  1  high in ACCUM.
REQ-012 done  output  1  one-cycle pulse, number complete.
REQ-013 err  output  1  sticky error flag.
REQ-014 ovf  output  1  sticky overflow flag, a subset of err.

Function
REQ-015 States: IDLE, ACCUM, DONE, ERR; the state register is the only control state.
REQ-016 Any state, start=1: next state ACCUM; value=0; digit_cnt=0; err=0; ovf=0; radix latched from hex_mode.
REQ-017 IDLE/DONE/ERR: char_valid is ignored.
REQ-018 Digit decode: '0'-'9' (8'h30-8'h39) -> char-8'h30; in hex mode only, 'a'-'f' and 'A'-'F' -> 10-15.
REQ-019 ACCUM, char_valid, valid digit, digit_cnt<MAX_DIGITS: value <= value*radix + digit (mod 2^WIDTH); digit_cnt increments; stays in ACCUM.
REQ-020 ACCUM, valid digit with digit_cnt==MAX_DIGITS: -> ERR, err=1; value unchanged.
REQ-021 ACCUM, char_valid, non-digit (terminator), digit_cnt>0: -> DONE; value unchanged.
REQ-022 ACCUM, non-digit with digit_cnt==0: -> ERR, err=1.
REQ-023 ACCUM, char_valid=0: hold all state.
REQ-024 done is high exactly in DONE, i.e. the cycle after the terminator is accepted; DONE -> IDLE unconditionally, unless start is high (REQ-016).
REQ-025 start has priority over char_valid in the same cycle; that char is discarded.
REQ-026 value, digit_cnt and err hold in IDLE and ERR until the next start or reset.
REQ-027 Decoding is purely combinational; the multiply-add completes in one cycle with no back-pressure, so one char is accepted per clock.

Reset
REQ-028 Reset (synchronous, active-high) -> IDLE, value=0, digit_cnt=0, done=0, err=0, ovf=0, latched radix=decimal.
REQ-029 Reset has priority over start and char_valid, and aborts any number in progress with no done pulse.

Configuration
REQ-030 Macro ASCII_NUM_PARSER_OVF_EN defined: if value*radix+digit exceeds 2^WIDTH-1, -> ERR with err=1 and ovf=1; value holds its pre-overflow contents.
REQ-031 Macro ASCII_NUM_PARSER_OVF_EN undefined: the result wraps mod 2^WIDTH; ovf is tied to 0; no overflow detection logic is present.

Structure
REQ-032 Package ascii_num_parser_pkg holds the state enum and the ASCII constants: ZERO=8'h30, NINE=8'h39, LA=8'h61, LF=8'h66, UA=8'h41, UF=8'h46.
REQ-033 Sub-module ascii_digit_decode is combinational: inputs char and hex; outputs digit[3:0] and is_digit. It replaces the fixed char-8'h30 conversion.

Verification
REQ-034 WIDTH=32, decimal: start, then '1','2','3',';' on consecutive cycles -> done high one cycle later, value=123, digit_cnt=3, err=0.
REQ-035 Hex mode: 'A','b','0','#' -> value=32'h0000AB0, done pulse; the same chars in decimal mode -> err=1 on 'A', no done.
REQ-036 start, then '#' immediately -> ERR, err=1, done never asserts; the next start clears err.
REQ-037 MAX_DIGITS=8, 9 decimal digits -> ERR on the 9th digit, value equals the first 8 digits.
REQ-038 WIDTH=8, decimal "300;" -> with ASCII_NUM_PARSER_OVF_EN: err=1, ovf=1, value=30; without it: done, value=44 (300 mod 256).
REQ-039 Reset after '4','5' mid-number -> IDLE, value=0, no done pulse. start asserted together with char_valid mid-number -> value=0, char ignored.
